// File: rtl/velocity_ring_sequencer.sv
// rtl/velocity_ring_sequencer.sv - velocity-exchange ring phase controller
// Flushes the ring nodes, opens injection, generates the slot strobe and detects drain or timeout.
module velocity_ring_sequencer #(
  parameter int NNODES        = 8,
  parameter int SLOT_CYCLES   = 16,
  parameter int FLUSH_CYCLES  = 4,
  parameter int DRAIN_SLOTS   = 2,
  parameter int TIMEOUT_SLOTS = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              src_done,
  input  logic [NNODES-1:0] rempty,
  output logic              ring_reset,
  output logic              inject_en,
  output logic              slot_tick,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [15:0]       slot_count
);

  localparam int PW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int DW = $clog2(DRAIN_SLOTS + 1);

  localparam logic [PW-1:0] PHASE_LAST = PW'(SLOT_CYCLES - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [DW-1:0] DRAIN_N    = DW'(DRAIN_SLOTS);
  localparam logic [15:0]   TO_MAX     = 16'(TIMEOUT_SLOTS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_INJECT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] phase;
  logic [FW-1:0] flush_cnt;
  logic [DW-1:0] drain_cnt;

  logic [PW-1:0] phase_next;
  logic [15:0]   slot_next;
  logic [DW-1:0] drain_next;
  logic          all_empty;

  always_comb begin
    phase_next = (phase == PHASE_LAST) ? '0 : phase + 1'b1;
    slot_next  = (slot_count == TO_MAX) ? slot_count : slot_count + 16'd1;
    drain_next = drain_cnt + 1'b1;
    all_empty  = &rempty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      phase      <= '0;
      flush_cnt  <= '0;
      drain_cnt  <= '0;
      ring_reset <= 1'b0;
      inject_en  <= 1'b0;
      slot_tick  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      slot_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_FLUSH;
            ring_reset <= 1'b1;
            busy       <= 1'b1;
            timeout    <= 1'b0;
            slot_count <= '0;
            flush_cnt  <= '0;
          end
        end
        S_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            // Nodes leave reset with their slot counter at its last value, so the first INJECT cycle is a boundary.
            state      <= S_INJECT;
            ring_reset <= 1'b0;
            inject_en  <= 1'b1;
            slot_tick  <= 1'b1;
            phase      <= PHASE_LAST;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        S_INJECT, S_DRAIN: begin
          phase     <= phase_next;
          slot_tick <= (phase_next == PHASE_LAST);
          if (slot_tick) begin
            slot_count <= slot_next;
            if (slot_next == TO_MAX) begin
              state     <= S_DONE;
              timeout   <= 1'b1;
              done      <= 1'b1;
              inject_en <= 1'b0;
              slot_tick <= 1'b0;
            end else if (state == S_INJECT) begin
              if (src_done) begin
                state     <= S_DRAIN;
                inject_en <= 1'b0;
                drain_cnt <= '0;
              end
            end else if (all_empty) begin
              if (drain_next == DRAIN_N) begin
                state     <= S_DONE;
                done      <= 1'b1;
                slot_tick <= 1'b0;
              end else begin
                drain_cnt <= drain_next;
              end
            end else begin
              drain_cnt <= '0;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_velocity_ring_sequencer.sv
// tb/tb_velocity_ring_sequencer.sv - scoreboard bench for velocity_ring_sequencer
// Instance 0 uses defaults; instance 1 uses TIMEOUT_SLOTS=8 for the abort path.
module tb_velocity_ring_sequencer;

  localparam int SIG_RR = 0, SIG_INJ = 1, SIG_TICK = 2, SIG_BUSY = 3,
                 SIG_DONE = 4, SIG_TO = 5, SIG_SC = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset0, start0, src_done0;
  logic [7:0]  rempty0;
  logic        rr0, inj0, tick0, busy0, done0, to0;
  logic [15:0] sc0;

  logic        reset1, start1, src_done1;
  logic [7:0]  rempty1;
  logic        rr1, inj1, tick1, busy1, done1, to1;
  logic [15:0] sc1;

  velocity_ring_sequencer dut0 (
    .clk(clk), .reset(reset0), .start(start0), .src_done(src_done0), .rempty(rempty0),
    .ring_reset(rr0), .inject_en(inj0), .slot_tick(tick0), .busy(busy0),
    .done(done0), .timeout(to0), .slot_count(sc0)
  );

  velocity_ring_sequencer #(.TIMEOUT_SLOTS(8)) dut1 (
    .clk(clk), .reset(reset1), .start(start1), .src_done(src_done1), .rempty(rempty1),
    .ring_reset(rr1), .inject_en(inj1), .slot_tick(tick1), .busy(busy1),
    .done(done1), .timeout(to1), .slot_count(sc1)
  );

  typedef struct { int inst; int cyc; int sig; int val; } exp_t;
  typedef struct { int cyc; int to; int sc; } done_t;

  exp_t  exp_q[$];
  done_t dq0[$];
  done_t dq1[$];

  int compared = 0;
  int mismatched = 0;
  logic end_req = 1'b0;
  logic end_done = 1'b0;

  function automatic string sig_name(input int s);
    case (s)
      SIG_RR:   return "ring_reset";
      SIG_INJ:  return "inject_en";
      SIG_TICK: return "slot_tick";
      SIG_BUSY: return "busy";
      SIG_DONE: return "done";
      SIG_TO:   return "timeout";
      default:  return "slot_count";
    endcase
  endfunction

  function automatic int get_sig(input int inst, input int s);
    if (inst == 0) begin
      case (s)
        SIG_RR:   return int'(rr0);
        SIG_INJ:  return int'(inj0);
        SIG_TICK: return int'(tick0);
        SIG_BUSY: return int'(busy0);
        SIG_DONE: return int'(done0);
        SIG_TO:   return int'(to0);
        default:  return int'(sc0);
      endcase
    end
    case (s)
      SIG_RR:   return int'(rr1);
      SIG_INJ:  return int'(inj1);
      SIG_TICK: return int'(tick1);
      SIG_BUSY: return int'(busy1);
      SIG_DONE: return int'(done1);
      SIG_TO:   return int'(to1);
      default:  return int'(sc1);
    endcase
  endfunction

  task automatic push(input int inst, input int c, input int s, input int v);
    exp_t e;
    e.inst = inst; e.cyc = c; e.sig = s; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic push_zero(input int inst, input int c);
    for (int s = SIG_RR; s <= SIG_SC; s++) push(inst, c, s, 0);
  endtask

  task automatic push_done(input int inst, input int c, input int t, input int s);
    done_t d;
    d.cyc = c; d.to = t; d.sc = s;
    if (inst == 0) dq0.push_back(d);
    else dq1.push_back(d);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int inst, input int act, input int expv);
    compared++;
    if (act != expv) begin
      mismatched++;
      $display("FAIL %s inst%0d cyc %0d: got %0d, expected %0d", name, inst, cyc, act, expv);
    end
  endtask

  task automatic chk_done(input int inst, input logic d, input logic t, input logic [15:0] s);
    done_t e;
    if (d !== 1'b1) return;
    if ((inst == 0 && dq0.size() == 0) || (inst == 1 && dq1.size() == 0)) begin
      chk("unexpected_done_cycle", inst, cyc, -1);
      return;
    end
    e = (inst == 0) ? dq0.pop_front() : dq1.pop_front();
    chk("done_cycle", inst, cyc, e.cyc);
    chk("done_timeout", inst, int'(t), e.to);
    chk("done_slot_count", inst, int'(s), e.sc);
  endtask

  // Monitor: retires every timed expectation and every done pulse.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < exp_q.size()) begin
      if (exp_q[i].cyc <= cyc) begin
        if (exp_q[i].cyc < cyc) chk("stale_expectation", exp_q[i].inst, cyc, exp_q[i].cyc);
        else chk(sig_name(exp_q[i].sig), exp_q[i].inst, get_sig(exp_q[i].inst, exp_q[i].sig), exp_q[i].val);
        exp_q.delete(i);
      end else begin
        i++;
      end
    end
    chk_done(0, done0, to0, sc0);
    chk_done(1, done1, to1, sc1);
    if (end_req && !end_done) begin
      foreach (exp_q[k]) chk("unchecked_expectation", exp_q[k].inst, exp_q[k].cyc, -1);
      foreach (dq0[k]) chk("missing_done_cycle", 0, -1, dq0[k].cyc);
      foreach (dq1[k]) chk("missing_done_cycle", 1, -1, dq1[k].cyc);
      end_done <= 1'b1;
    end
  end

  int b;

  initial begin
    reset0 = 1'b1; start0 = 1'b0; src_done0 = 1'b0; rempty0 = 8'hFF;
    reset1 = 1'b1; start1 = 1'b0; src_done1 = 1'b0; rempty1 = 8'hFF;
    push_zero(0, 2);
    push_zero(1, 2);
    wait_cyc(4);
    reset0 = 1'b0; reset1 = 1'b0;

    // Nominal phase with stray start pulses during the phase.
    b = cyc;
    push(0, b+10, SIG_BUSY, 0);
    for (int c = 11; c <= 14; c++) push(0, b+c, SIG_RR, 1);
    push(0, b+11, SIG_BUSY, 1);
    push(0, b+15, SIG_RR, 0);   push(0, b+15, SIG_INJ, 1); push(0, b+15, SIG_TICK, 1);
    push(0, b+16, SIG_TICK, 0); push(0, b+30, SIG_TICK, 0); push(0, b+31, SIG_TICK, 1);
    push(0, b+21, SIG_RR, 0);   push(0, b+47, SIG_TICK, 1);
    push(0, b+63, SIG_TICK, 1); push(0, b+63, SIG_INJ, 1); push(0, b+64, SIG_INJ, 0);
    push(0, b+71, SIG_RR, 0);   push(0, b+71, SIG_BUSY, 1); push(0, b+79, SIG_TICK, 1);
    push(0, b+95, SIG_DONE, 0); push(0, b+96, SIG_BUSY, 1);
    push(0, b+97, SIG_DONE, 0); push(0, b+97, SIG_BUSY, 0); push(0, b+98, SIG_SC, 6);
    push_done(0, b+96, 0, 6);
    wait_cyc(b+10); start0 = 1'b1;
    wait_cyc(b+11); start0 = 1'b0;
    wait_cyc(b+20); start0 = 1'b1;
    wait_cyc(b+21); start0 = 1'b0;
    wait_cyc(b+50); src_done0 = 1'b1;
    wait_cyc(b+70); start0 = 1'b1;
    wait_cyc(b+71); start0 = 1'b0;
    wait_cyc(b+100); src_done0 = 1'b0;

    // One node not empty at the first drain tick restarts the drain count.
    b = cyc;
    push(0, b+64, SIG_INJ, 0);  push(0, b+80, SIG_BUSY, 1);
    push(0, b+96, SIG_DONE, 0); push(0, b+96, SIG_BUSY, 1);
    push(0, b+111, SIG_TICK, 1); push(0, b+113, SIG_BUSY, 0);
    push_done(0, b+112, 0, 7);
    wait_cyc(b+10); start0 = 1'b1;
    wait_cyc(b+11); start0 = 1'b0;
    wait_cyc(b+50); src_done0 = 1'b1;
    wait_cyc(b+79); rempty0 = 8'hFB;
    wait_cyc(b+80); rempty0 = 8'hFF;
    wait_cyc(b+115); src_done0 = 1'b0;

    // Reset during DRAIN, then a minimum-length phase.
    b = cyc;
    push(0, b+80, SIG_BUSY, 1);
    push_zero(0, b+81);
    for (int c = 91; c <= 94; c++) push(0, b+c, SIG_RR, 1);
    push(0, b+95, SIG_RR, 0); push(0, b+95, SIG_TICK, 1); push(0, b+96, SIG_INJ, 0);
    push(0, b+129, SIG_BUSY, 0);
    push_done(0, b+128, 0, 3);
    wait_cyc(b+10); start0 = 1'b1;
    wait_cyc(b+11); start0 = 1'b0;
    wait_cyc(b+50); src_done0 = 1'b1;
    wait_cyc(b+80); reset0 = 1'b1;
    wait_cyc(b+81); reset0 = 1'b0;
    wait_cyc(b+90); start0 = 1'b1;
    wait_cyc(b+91); start0 = 1'b0;
    wait_cyc(b+132); src_done0 = 1'b0;

    // Timeout with TIMEOUT_SLOTS=8 and sources never finishing.
    b = cyc;
    push(1, b+126, SIG_TO, 0); push(1, b+127, SIG_TICK, 1);
    push(1, b+128, SIG_TO, 1); push(1, b+129, SIG_BUSY, 0);
    push(1, b+140, SIG_TO, 1); push(1, b+150, SIG_TO, 1);
    push(1, b+151, SIG_TO, 0); push(1, b+151, SIG_RR, 1); push(1, b+151, SIG_SC, 0);
    push_done(1, b+128, 1, 8);
    push_done(1, b+268, 1, 8);
    wait_cyc(b+10); start1 = 1'b1;
    wait_cyc(b+11); start1 = 1'b0;
    wait_cyc(b+150); start1 = 1'b1;
    wait_cyc(b+151); start1 = 1'b0;
    wait_cyc(b+275);

    end_req = 1'b1;
    for (int k = 0; k < 10 && !end_done; k++) @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
